// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the BCD stopwatch core:
//   - sw_state_t : control FSM states (IDLE, RUN, LAP, STOP)
//   - SEL_*      : scan-select index of each displayed digit (0 = leftmost)
//   - DIGIT_MAX / DIGIT_MAX_TENS : BCD digit maxima for 0-9 and 0-5 digits
//   - DIGIT_INVALID : code returned on bcd_out for an unused scan position
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } sw_state_t;

    localparam logic [2:0] SEL_M1 = 3'd0;
    localparam logic [2:0] SEL_M0 = 3'd1;
    localparam logic [2:0] SEL_S1 = 3'd2;
    localparam logic [2:0] SEL_S0 = 3'd3;
    localparam logic [2:0] SEL_C1 = 3'd4;
    localparam logic [2:0] SEL_C0 = 3'd5;

    localparam logic [3:0] DIGIT_MAX      = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;
    localparam logic [3:0] DIGIT_INVALID  = 4'hF;

    localparam int NUM_DIGITS = 6;

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
// One BCD digit that counts 0..MAX and rolls back to 0.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : advance by one this cycle
//   clr        : force digit to zero (wins over inc)
//   digit      : current digit value
//   carry      : high when inc arrives while digit == MAX (feeds next digit)
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_reg <= 4'd0;
        end else if (clr) begin
            digit_reg <= 4'd0;
        end else if (inc) begin
            digit_reg <= (digit_reg == MAX) ? 4'd0 : digit_reg + 4'd1;
        end
    end

    assign digit = digit_reg;
    // Combinational so a whole ripple of carries lands on the same edge.
    assign carry = inc && (digit_reg == MAX);

endmodule

// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core
// Six-digit MM:SS.cc BCD stopwatch with start/stop and lap/clear control.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   tick_in    : slow tick square wave (asynchronous, synchronized here)
//   btn_ss     : start/stop button level
//   btn_lr     : lap/clear button level
//   seg7_sel   : scan position 0..5 (6, 7 invalid)
//   bcd_out    : digit at seg7_sel, 4'hF when invalid
//   disp_bcd   : {m1,m0,s1,s0,c1,c0} as displayed (lap latch while in LAP)
//   running    : high in RUN and LAP
//   frozen     : high in LAP
//   wrap       : one-cycle pulse when MIN_LIMIT:59.99 rolls to 00:00.00
module stopwatch_bcd_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        btn_ss,
    input  logic        btn_lr,
    input  logic [2:0]  seg7_sel,
    output logic [3:0]  bcd_out,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        frozen,
    output logic        wrap
);

    localparam logic [3:0] MIN_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_ONES = 4'(MIN_LIMIT % 10);

    // Synchronizers and rising-edge detectors: bit 0 tick, 1 ss, 2 lr.
    logic [2:0] sync1_reg, sync2_reg, prev_reg;
    logic [2:0] ev;
    logic       tick_ev, ss_ev, lr_ev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 3'd0;
            sync2_reg <= 3'd0;
            prev_reg  <= 3'd0;
        end else begin
            sync1_reg <= {btn_lr, btn_ss, tick_in};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign ev      = sync2_reg & ~prev_reg;
    assign tick_ev = ev[0];
    assign ss_ev   = ev[1];
    assign lr_ev   = ev[2];

    sw_state_t   state_reg;
    logic        running_reg, frozen_reg, wrap_reg;
    logic [23:0] lap_reg;

    // Counter digits: index 0 = c0 ... 5 = m1, packed so count matches disp order.
    logic [23:0] count;
    logic [NUM_DIGITS-1:0] dig_inc, dig_carry;
    logic count_en, at_limit, wrap_hit, clear_all;

    assign count_en = tick_ev && ((state_reg == RUN) || (state_reg == LAP));
    assign at_limit = (count[23:20] == MIN_TENS) && (count[19:16] == MIN_ONES);
    // dig_carry[3] means SS.cc is at 59.99 and about to roll. The m1 carry
    // covers 99:59.99, which only occurs when MIN_LIMIT is 99.
    assign wrap_hit = dig_carry[3] && (at_limit || dig_carry[5]);
    // Clear on wrap, or STOP + lr when no ss competes (ss has priority).
    assign clear_all = wrap_hit || ((state_reg == STOP) && lr_ev && !ss_ev);

    assign dig_inc[0] = count_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_mod_counter #(
                .MAX((gi == 3) ? DIGIT_MAX_TENS : DIGIT_MAX)
            ) u_digit (
                .clk  (clk),
                .reset(reset),
                .inc  (dig_inc[gi]),
                .clr  (clear_all),
                .digit(count[gi*4 +: 4]),
                .carry(dig_carry[gi])
            );
            if (gi < NUM_DIGITS - 1) begin : g_chain
                assign dig_inc[gi+1] = dig_carry[gi];
            end
        end
    endgenerate

    // Control FSM; the counter sees state_reg before this edge's transition,
    // so a coincident tick is applied with the old state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
            frozen_reg  <= 1'b0;
            wrap_reg    <= 1'b0;
            lap_reg     <= 24'd0;
        end else begin
            wrap_reg <= wrap_hit;
            case (state_reg)
                IDLE: begin
                    if (ss_ev) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (ss_ev) begin
                        state_reg   <= STOP;
                        running_reg <= 1'b0;
                    end else if (lr_ev) begin
                        state_reg  <= LAP;
                        frozen_reg <= 1'b1;
                        lap_reg    <= count;
                    end
                end
                LAP: begin
                    if (ss_ev) begin
                        state_reg   <= STOP;
                        running_reg <= 1'b0;
                        frozen_reg  <= 1'b0;
                    end else if (lr_ev) begin
                        state_reg  <= RUN;
                        frozen_reg <= 1'b0;
                    end
                end
                STOP: begin
                    if (ss_ev) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end else if (lr_ev) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                    frozen_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign disp_bcd = (state_reg == LAP) ? lap_reg : count;
    assign running  = running_reg;
    assign frozen   = frozen_reg;
    assign wrap     = wrap_reg;

    always_comb begin
        bcd_out = DIGIT_INVALID;
        case (seg7_sel)
            SEL_M1:  bcd_out = disp_bcd[23:20];
            SEL_M0:  bcd_out = disp_bcd[19:16];
            SEL_S1:  bcd_out = disp_bcd[15:12];
            SEL_S0:  bcd_out = disp_bcd[11:8];
            SEL_C1:  bcd_out = disp_bcd[7:4];
            SEL_C0:  bcd_out = disp_bcd[3:0];
            default: bcd_out = DIGIT_INVALID;
        endcase
    end

endmodule
